// File: rtl/pmod_dac_pkg.sv
// Shared FSM encoding and default timing constants for the PMOD DAC request arbiter.
package pmod_dac_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StXfer,
    StGap
  } state_e;

  localparam int unsigned DefResolution = 16;
  localparam int unsigned DefXferCycles = 18;
  localparam int unsigned DefGapCycles  = 2;

endpackage

// File: rtl/pmod_dac_arbiter_if.sv
// Requester/DAC-side bundle of the arbiter: level requests in, one-hot strobes and DAC controls out.
interface pmod_dac_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned RESOLUTION = 16
);
  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*RESOLUTION-1:0] req_data;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            done;
  logic [RESOLUTION-1:0]         dac_data;
  logic                          dac_load;
  logic                          dac_start;
  logic                          busy;
  logic [IdW-1:0]                active_id;

  modport master (
    output req, req_data,
    input  grant, done, dac_data, dac_load, dac_start, busy, active_id
  );

  modport slave (
    input  req, req_data,
    output grant, done, dac_data, dac_load, dac_start, busy, active_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Stateless round-robin picker: first set request at or above ptr_i, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);
  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic           found;
  logic [IdW-1:0] k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      k = IdW'((32'(ptr_i) + off) % NUM_REQ);
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/pmod_dac_arbiter.sv
// Round-robin arbiter that serialises requester words onto a single PMOD DAC,
// sequencing load, start, a fixed transfer window and an idle guard gap.
module pmod_dac_arbiter
  import pmod_dac_pkg::*;
#(
  parameter int unsigned RESOLUTION  = DefResolution,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned XFER_CYCLES = DefXferCycles,
  parameter int unsigned GAP_CYCLES  = DefGapCycles
) (
  input logic               clk,
  input logic               rst_n,
  pmod_dac_arbiter_if.slave bus
);
  localparam int unsigned IdW      = $clog2(NUM_REQ);
  localparam logic [7:0]  XferLast = 8'(XFER_CYCLES - 1);
  localparam logic [7:0]  GapLast  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_e                state_q;
  logic [NUM_REQ-1:0]    grant_q, done_q;
  logic [RESOLUTION-1:0] dac_data_q;
  logic                  dac_load_q, dac_start_q, busy_q;
  logic [IdW-1:0]        active_id_q, ptr_q, ptr_d;
  logic [7:0]            cnt_q;

  logic [NUM_REQ-1:0]    rr_gnt;
  logic [IdW-1:0]        rr_idx;
  logic [RESOLUTION-1:0] words [NUM_REQ];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = bus.req_data[g*RESOLUTION +: RESOLUTION];
  end

  assign ptr_d = (rr_idx == IdW'(NUM_REQ - 1)) ? '0 : rr_idx + IdW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      done_q      <= '0;
      dac_data_q  <= '0;
      dac_load_q  <= 1'b0;
      dac_start_q <= 1'b0;
      busy_q      <= 1'b0;
      active_id_q <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= '0;
          if (|bus.req) begin
            state_q     <= StLoad;
            grant_q     <= rr_gnt;
            dac_load_q  <= 1'b1;
            busy_q      <= 1'b1;
            dac_data_q  <= words[rr_idx];
            active_id_q <= rr_idx;
            ptr_q       <= ptr_d;
          end
        end
        StLoad: begin
          state_q     <= StStart;
          grant_q     <= '0;
          dac_load_q  <= 1'b0;
          dac_start_q <= 1'b1;
        end
        StStart: begin
          state_q     <= StXfer;
          dac_start_q <= 1'b0;
          cnt_q       <= '0;
        end
        StXfer: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == XferLast) begin
            done_q <= NUM_REQ'(1) << active_id_q;
            cnt_q  <= '0;
            // With no guard gap the done pulse lands in the first IDLE cycle.
            if (GAP_CYCLES > 0) begin
              state_q <= StGap;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        StGap: begin
          done_q <= '0;
          cnt_q  <= cnt_q + 8'd1;
          if (cnt_q == GapLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.dac_data  = dac_data_q;
  assign bus.dac_load  = dac_load_q;
  assign bus.dac_start = dac_start_q;
  assign bus.busy      = busy_q;
  assign bus.active_id = active_id_q;

endmodule

// File: tb/tb_pmod_dac_arbiter.sv
// Directed bench for pmod_dac_arbiter: default-timing instance plus a GAP=0/XFER=1 instance.
module tb_pmod_dac_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pmod_dac_arbiter_if #(.NUM_REQ(4), .RESOLUTION(16)) bus ();
  pmod_dac_arbiter_if #(.NUM_REQ(4), .RESOLUTION(16)) bus2 ();

  pmod_dac_arbiter #(
    .RESOLUTION  (16),
    .NUM_REQ     (4),
    .XFER_CYCLES (18),
    .GAP_CYCLES  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pmod_dac_arbiter #(
    .RESOLUTION  (16),
    .NUM_REQ     (4),
    .XFER_CYCLES (1),
    .GAP_CYCLES  (0)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Structural invariants checked every cycle on both instances.
  always @(negedge clk) begin
    checks++;
    assert (!(bus.dac_load && bus.dac_start) && $onehot0(bus.grant) && $onehot0(bus.done) &&
            !(bus2.dac_load && bus2.dac_start) && $onehot0(bus2.grant) && $onehot0(bus2.done))
    else begin
      errors++;
      $error("FAIL invariant observed load/start/grant/done %b%b %b %b expected exclusive",
             bus.dac_load, bus.dac_start, bus.grant, bus.done);
    end
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.req_data  = '0;
    bus2.req      = '0;
    bus2.req_data = '0;
    tick(2);

    // Reset state.
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_data", 32'(bus.dac_data), 32'h0);
    chk("rst_id", 32'(bus.active_id), 32'h0);
    chk("rst_loadstart", {30'd0, bus.dac_load, bus.dac_start}, 32'h0);
    rst_n = 1'b1;

    // Single requester 2, word A5A5.
    bus.req      = 4'b0100;
    bus.req_data = {16'h0, 16'hA5A5, 16'h0, 16'h0};
    tick(1);
    chk("c0_grant", 32'(bus.grant), 32'h4);
    chk("c0_load", 32'(bus.dac_load), 32'h1);
    chk("c0_data", 32'(bus.dac_data), 32'hA5A5);
    chk("c0_id", 32'(bus.active_id), 32'h2);
    chk("c0_busy", 32'(bus.busy), 32'h1);
    bus.req = '0;
    tick(1);
    chk("c1_start", 32'(bus.dac_start), 32'h1);
    chk("c1_grant", 32'(bus.grant), 32'h0);
    tick(18);
    chk("c19_done", 32'(bus.done), 32'h0);
    tick(1);
    chk("c20_done", 32'(bus.done), 32'h4);
    chk("c20_busy", 32'(bus.busy), 32'h1);
    tick(1);
    chk("c21_done", 32'(bus.done), 32'h0);
    chk("c21_busy", 32'(bus.busy), 32'h1);
    tick(1);
    chk("c22_busy", 32'(bus.busy), 32'h0);

    // Reset between idle transfers, then all four requesting.
    rst_n = 1'b0;
    #1;
    chk("rst2_busy", 32'(bus.busy), 32'h0);
    tick(1);
    rst_n        = 1'b1;
    bus.req      = 4'b1111;
    bus.req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    tick(1);
    for (int k = 0; k < 5; k++) begin
      chk("rr_grant", 32'(bus.grant), 32'h1 << (k % 4));
      chk("rr_data", 32'(bus.dac_data), 32'h1111 * ((k % 4) + 1));
      if (k < 4) tick(23);
    end
    bus.req = '0;
    tick(22);
    chk("rr_idle", 32'(bus.busy), 32'h0);

    // Pointer is 1; single grant to 1 moves it to 2.
    bus.req = 4'b0010;
    tick(1);
    chk("p2_grant", 32'(bus.grant), 32'h2);
    bus.req = '0;
    tick(22);
    chk("p2_idle", 32'(bus.busy), 32'h0);
    bus.req = 4'b1010;
    tick(1);
    chk("tie_first", 32'(bus.grant), 32'h8);
    tick(23);
    chk("tie_second", 32'(bus.grant), 32'h2);
    bus.req = '0;
    tick(22);
    bus.req = 4'b1111;
    tick(1);
    chk("tie_ptr2", 32'(bus.grant), 32'h4);
    bus.req = '0;
    tick(22);

    // Single-cycle request from 0, data changed after capture.
    bus.req      = 4'b0001;
    bus.req_data = {16'h0, 16'h0, 16'h0, 16'h0123};
    tick(1);
    chk("pulse_grant", 32'(bus.grant), 32'h1);
    chk("pulse_data0", 32'(bus.dac_data), 32'h0123);
    bus.req      = '0;
    bus.req_data = {16'h0, 16'h0, 16'h0, 16'hFFFF};
    tick(1);
    chk("pulse_data1", 32'(bus.dac_data), 32'h0123);
    tick(19);
    chk("pulse_done", 32'(bus.done), 32'h1);
    chk("pulse_data20", 32'(bus.dac_data), 32'h0123);
    tick(2);
    chk("pulse_idle", 32'(bus.busy), 32'h0);

    // Reset during XFER cycle 7.
    bus.req = 4'b0100;
    tick(1);
    chk("abort_grant", 32'(bus.grant), 32'h4);
    bus.req = '0;
    tick(8);
    rst_n   = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_data", 32'(bus.dac_data), 32'h0);
    chk("abort_id", 32'(bus.active_id), 32'h0);
    chk("abort_ctl", {bus.grant, bus.done, 22'd0, bus.dac_load, bus.dac_start}, 32'h0);
    bus.req = 4'b0110;
    tick(12);
    chk("abort_nodone", 32'(bus.done), 32'h0);
    rst_n = 1'b1;
    tick(1);
    chk("abort_regrant", 32'(bus.grant), 32'h2);
    chk("abort_id1", 32'(bus.active_id), 32'h1);
    bus.req = '0;
    tick(22);

    // GAP_CYCLES=0, XFER_CYCLES=1 instance with req[0] held.
    bus2.req      = 4'b0001;
    bus2.req_data = {16'h0, 16'h0, 16'h0, 16'hBEEF};
    tick(1);
    chk("g0_grant0", 32'(bus2.grant), 32'h1);
    chk("g0_data", 32'(bus2.dac_data), 32'hBEEF);
    tick(1);
    chk("g0_start", 32'(bus2.dac_start), 32'h1);
    tick(1);
    chk("g0_xfer_done", 32'(bus2.done), 32'h0);
    tick(1);
    chk("g0_done", 32'(bus2.done), 32'h1);
    chk("g0_done_idle", 32'(bus2.busy), 32'h0);
    chk("g0_done_grant", 32'(bus2.grant), 32'h0);
    tick(1);
    chk("g0_grant1", 32'(bus2.grant), 32'h1);
    tick(4);
    chk("g0_grant2", 32'(bus2.grant), 32'h1);
    bus2.req = '0;
    tick(4);
    chk("g0_idle", 32'(bus2.busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmod_dac_arbiter.md
PMOD_DAC_ARBITER -- requirements
Module: pmod_dac_arbiter

Interface
REQ-001 SHALL have parameter RESOLUTION, default 16: DAC word width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-003 SHALL have parameter XFER_CYCLES, default 18: cycles to wait after start for the DAC serial transfer, legal range 1..255.
REQ-004 SHALL have parameter GAP_CYCLES, default 2: idle guard cycles between transfers, legal range 0..15.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req  in  NUM_REQ  per-requester level request; bit i means requester i has a word pending.
REQ-008 req_data  in  NUM_REQ*RESOLUTION  packed words; requester i occupies bits [i*RESOLUTION +: RESOLUTION].
REQ-009 grant  out  NUM_REQ  one-hot, one-cycle pulse when the requester's word is captured.
REQ-010 done  out  NUM_REQ  one-hot, one-cycle pulse when the requester's transfer window ends.
REQ-011 dac_data  out  RESOLUTION  word presented to the DAC block din.
REQ-012 dac_load  out  1  drives the DAC block load_din.
REQ-013 dac_start  out  1  drives the DAC block start.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.
REQ-015 active_id  out  clog2(NUM_REQ)  index of the current or most recent grantee.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, START, XFER and GAP; all outputs SHALL be registered.
REQ-017 IDLE: on an edge where any req bit is high, SHALL select requester i by round-robin, capture req_data word i into dac_data, set active_id=i and enter LOAD; otherwise SHALL remain in IDLE.
REQ-018 Round-robin: search SHALL start at pointer p and ascend modulo NUM_REQ; after a grant to i, p SHALL become (i+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
REQ-019 LOAD (1 cycle): grant[i]=1 and dac_load=1; next state START.
REQ-020 START (1 cycle): dac_start=1; next state XFER; the cycle counter SHALL be cleared.
REQ-021 XFER: the counter SHALL increment each cycle; after exactly XFER_CYCLES cycles, SHALL leave XFER.
REQ-022 On leaving XFER, done[i] SHALL pulse for the first cycle of the next state; next state SHALL be GAP if GAP_CYCLES>0, else IDLE.
REQ-023 GAP: SHALL last exactly GAP_CYCLES cycles, then IDLE.
REQ-024 dac_data SHALL hold the captured word from LOAD until the next capture; later req_data changes SHALL have no effect on it.
REQ-025 req changes outside IDLE SHALL be ignored; a request dropped after its grant SHALL still complete and pulse done.
REQ-026 A requester holding req high across its own done SHALL be re-eligible at the next IDLE under the normal round-robin order.
REQ-027 dac_load and dac_start SHALL never be high in the same cycle; at most one grant bit and one done bit SHALL be high in any cycle.
REQ-028 Transfer period: grant to grant for a back-to-back requester SHALL be 3+XFER_CYCLES+GAP_CYCLES cycles (LOAD+START+XFER+GAP+IDLE).

Reset
REQ-029 With rst_n low, the block SHALL immediately force state IDLE; grant, done, dac_load, dac_start and busy SHALL be 0; dac_data, active_id, the counter and p SHALL be 0.
REQ-030 Reset asserted mid-transfer SHALL abort it with no done pulse; the first arbitration after release SHALL start from requester 0.

Structure
REQ-031 The FSM state encoding and the default RESOLUTION, XFER_CYCLES and GAP_CYCLES constants SHALL live in shared package pmod_dac_pkg.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter, with inputs req and pointer and outputs a one-hot grant and an index, and no internal state.

Verification
REQ-033 Only req[2]=1, word 0xA5A5, defaults: grant[2], dac_load and dac_data=0xA5A5 in cycle 0; dac_start in cycle 1; done[2] in cycle 20; busy low from cycle 22.
REQ-034 req=4'b1111 held, words 0x1111/0x2222/0x3333/0x4444: grants in order 0,1,2,3,0 every 23 cycles, with matching dac_data.
REQ-035 req[1] and req[3] rise in the same cycle with p=2: grant[3] first, then grant[1]; p ends at 2.
REQ-036 req[0] pulsed for a single cycle and req_data changed to 0xFFFF after the grant: done[0] still pulses and dac_data stays at the original 0x0123.
REQ-037 rst_n driven low in XFER cycle 7: all outputs 0 at once, no done; after release with req=4'b0110, the first grant goes to requester 1.
REQ-038 GAP_CYCLES=0, XFER_CYCLES=1, req[0] held: grant to grant period is 4 cycles, and done[0] coincides with IDLE.
